wb_arbiter: RTL and testbench

- Shares the ROB writeback ports and IQ forwarding bus between four completion sources: functional units 0/1/2 and the load-store unit.
- Each source has a small per-requester FIFO with a valid/ready handshake.
- A round-robin scheduler drains up to NUM_PORTS entries per cycle onto registered writeback ports.
- Sits between the EX/MEM pipeline buffer plus load-store unit and the reorder_buffer writeback inputs, so the ROB does not need one write port per source.

---
 rtl/wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: funnels completions from three functional units and the
// load-store unit into two registered writeback ports. Each source owns a
// small FIFO; a round-robin scan grants up to two FIFO heads per cycle.
module wb_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_PORTS  = 2,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 6,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ*TAG_W-1:0]             req_rob_idx,
   input  logic [NUM_REQ*TAG_W-1:0]             req_phys_rd,
   input  logic [NUM_REQ*DATA_W-1:0]            req_value,
   output logic [NUM_PORTS-1:0]                 wb_valid,
   output logic [NUM_PORTS*TAG_W-1:0]           wb_rob_idx,
   output logic [NUM_PORTS*TAG_W-1:0]           wb_phys_rd,
   output logic [NUM_PORTS*DATA_W-1:0]          wb_value,
   output logic [NUM_PORTS*$clog2(NUM_REQ)-1:0] wb_src,
   output logic                                 arb_conflict
);

   localparam int REQ_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [TAG_W-1:0]  rob_idx;
      logic [TAG_W-1:0]  phys_rd;
      logic [DATA_W-1:0] value;
   } entry_t;

   // FIFO storage and bookkeeping
   entry_t           r_mem   [NUM_REQ][FIFO_DEPTH];
   logic [PTR_W-1:0] r_rptr  [NUM_REQ];
   logic [PTR_W-1:0] r_wptr  [NUM_REQ];
   logic [CNT_W-1:0] r_count [NUM_REQ];
   logic [REQ_W-1:0] r_rr_ptr;

   // Output registers
   logic [NUM_PORTS-1:0]        r_wb_valid;
   logic [NUM_PORTS*TAG_W-1:0]  r_wb_rob_idx;
   logic [NUM_PORTS*TAG_W-1:0]  r_wb_phys_rd;
   logic [NUM_PORTS*DATA_W-1:0] r_wb_value;
   logic [NUM_PORTS*REQ_W-1:0]  r_wb_src;
   logic                        r_arb_conflict;

   // Combinational helpers
   entry_t               w_in   [NUM_REQ];
   entry_t               w_head [NUM_REQ];
   logic [NUM_REQ-1:0]   w_nonempty;
   logic [NUM_REQ-1:0]   w_push;
   logic [NUM_REQ-1:0]   w_grant;
   logic [NUM_PORTS-1:0] w_port_valid;
   logic [REQ_W-1:0]     w_port_src [NUM_PORTS];
   logic [REQ_W-1:0]     w_scan_idx;
   logic [REQ_W-1:0]     w_next_ptr;
   logic                 w_conflict;

   // Per-requester status, incoming entry unpacking and FIFO head selection
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         // Ready comes from the registered count only, so a same-cycle pop
         // never opens a slot early.
         req_ready[i]  = (r_count[i] != CNT_W'(FIFO_DEPTH)) && !reset;
         w_nonempty[i] = (r_count[i] != '0);
         w_in[i]       = '{rob_idx: req_rob_idx[i*TAG_W +: TAG_W],
                           phys_rd: req_phys_rd[i*TAG_W +: TAG_W],
                           value:   req_value[i*DATA_W +: DATA_W]};
         w_head[i]     = r_mem[i][r_rptr[i]];
      end
   end

   assign w_push     = req_valid & req_ready & ~{NUM_REQ{flush}};
   assign w_conflict = ($countones(w_nonempty) > 2);

   // Round-robin scan from r_rr_ptr: first non-empty FIFO to port 0, second to port 1
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional logic; a path that leaves one unassigned infers a latch.
      w_grant      = '0;
      w_port_valid = '0;
      w_port_src   = '{default: '0};
      w_next_ptr   = r_rr_ptr;
      w_scan_idx   = r_rr_ptr;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_scan_idx = r_rr_ptr + REQ_W'(j);
         if (w_nonempty[w_scan_idx] && !w_port_valid[1]) begin
            if (!w_port_valid[0]) begin
               w_port_valid[0] = 1'b1;
               w_port_src[0]   = w_scan_idx;
            end else begin
               w_port_valid[1] = 1'b1;
               w_port_src[1]   = w_scan_idx;
            end
            w_grant[w_scan_idx] = 1'b1;
            w_next_ptr          = w_scan_idx + REQ_W'(1);
         end
      end
   end

   // FIFO pointers and occupancy; a flush empties everything
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_rptr[i]  <= '0;
            r_wptr[i]  <= '0;
            r_count[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_rptr[i]  <= '0;
            r_wptr[i]  <= '0;
            r_count[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_push[i])  r_wptr[i] <= r_wptr[i] + PTR_W'(1);
            if (w_grant[i]) r_rptr[i] <= r_rptr[i] + PTR_W'(1);
            case ({w_push[i], w_grant[i]})
               2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
               2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
               default: r_count[i] <= r_count[i];
            endcase
         end
      end
   end

   // FIFO payload storage, written at the tail on each accepted push
   always_ff @(posedge clk) begin
      // NOTE: the payload array has no reset; occupancy is tracked by the
      // counters, so stale contents are never observed.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_push[i]) r_mem[i][r_wptr[i]] <= w_in[i];
      end
   end

   // Writeback registers: granted heads load, idle ports drop valid and hold data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr       <= '0;
         r_wb_valid     <= '0;
         r_wb_rob_idx   <= '0;
         r_wb_phys_rd   <= '0;
         r_wb_value     <= '0;
         r_wb_src       <= '0;
         r_arb_conflict <= 1'b0;
      end else if (flush) begin
         r_rr_ptr       <= '0;
         r_wb_valid     <= '0;
         r_arb_conflict <= 1'b0;
      end else begin
         r_rr_ptr       <= w_next_ptr;
         r_wb_valid     <= w_port_valid;
         r_arb_conflict <= w_conflict;
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_port_valid[k]) begin
               r_wb_rob_idx[k*TAG_W +: TAG_W]   <= w_head[w_port_src[k]].rob_idx;
               r_wb_phys_rd[k*TAG_W +: TAG_W]   <= w_head[w_port_src[k]].phys_rd;
               r_wb_value[k*DATA_W +: DATA_W]   <= w_head[w_port_src[k]].value;
               r_wb_src[k*REQ_W +: REQ_W]       <= w_port_src[k];
            end
         end
      end
   end

   assign wb_valid     = r_wb_valid;
   assign wb_rob_idx   = r_wb_rob_idx;
   assign wb_phys_rd   = r_wb_phys_rd;
   assign wb_value     = r_wb_value;
   assign wb_src       = r_wb_src;
   assign arb_conflict = r_arb_conflict;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus for wb_arbiter with hand-computed
// expectations for each step.
module tb_wb_arbiter;

   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   logic          clk;
   logic          reset;
   logic          flush;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [23:0]   req_rob_idx;
   logic [23:0]   req_phys_rd;
   logic [127:0]  req_value;
   logic [1:0]    wb_valid;
   logic [11:0]   wb_rob_idx;
   logic [11:0]   wb_phys_rd;
   logic [63:0]   wb_value;
   logic [3:0]    wb_src;
   logic          arb_conflict;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt0;
   int cnt2;

   wb_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rob_idx  (req_rob_idx),
      .req_phys_rd  (req_phys_rd),
      .req_value    (req_value),
      .wb_valid     (wb_valid),
      .wb_rob_idx   (wb_rob_idx),
      .wb_phys_rd   (wb_phys_rd),
      .wb_value     (wb_value),
      .wb_src       (wb_src),
      .arb_conflict (arb_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [5:0] rob, input logic [5:0] rd,
                          input logic [31:0] val);
      req_rob_idx[i*TAG_W +: TAG_W]  = rob;
      req_phys_rd[i*TAG_W +: TAG_W]  = rd;
      req_value[i*DATA_W +: DATA_W]  = val;
   endtask

   initial begin
      reset       = 1'b0;
      flush       = 1'b0;
      req_valid   = '0;
      req_rob_idx = '0;
      req_phys_rd = '0;
      req_value   = '0;

      // ---------------- reset state ----------------
      #1 reset = 1'b1;
      tick();
      check("rst_wb_valid", wb_valid, 2'b00);
      check("rst_ready_low", req_ready, 4'h0);
      check("rst_conflict", arb_conflict, 1'b0);
      check("rst_src", wb_src, 4'h0);
      check("rst_value", wb_value, 64'h0);
      tick();
      reset = 1'b0;
      #1;
      check("rel_ready", req_ready, 4'hF);

      // ---------------- single push on req1 ----------------
      set_req(1, 6'd5, 6'd12, 32'hDEADBEEF);
      req_valid = 4'b0010;
      tick();                                // push edge
      req_valid = '0;
      check("single_not_yet", wb_valid, 2'b00);
      tick();
      check("single_valid", wb_valid, 2'b01);
      check("single_rob", wb_rob_idx[5:0], 6'd5);
      check("single_rd", wb_phys_rd[5:0], 6'd12);
      check("single_val", wb_value[31:0], 32'hDEADBEEF);
      check("single_src", wb_src[1:0], 2'd1);
      check("single_conflict", arb_conflict, 1'b0);
      tick();
      check("single_idle", wb_valid, 2'b00);
      check("single_hold_rob", wb_rob_idx[5:0], 6'd5);

      // flush to bring rr_ptr back to 0
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // ---------------- four simultaneous pushes ----------------
      for (int i = 0; i < 4; i++)
         set_req(i, 6'(i + 1), 6'(i + 11), 32'h100 + 32'(i));
      req_valid = 4'b1111;
      tick();
      req_valid = '0;
      check("four_not_yet", wb_valid, 2'b00);
      tick();
      check("four_a_valid", wb_valid, 2'b11);
      check("four_a_src", wb_src, 4'b0100);
      check("four_a_rob", wb_rob_idx, {6'd2, 6'd1});
      check("four_a_rd", wb_phys_rd, {6'd12, 6'd11});
      check("four_a_val", wb_value, {32'h101, 32'h100});
      check("four_a_conflict", arb_conflict, 1'b1);
      tick();
      check("four_b_valid", wb_valid, 2'b11);
      check("four_b_src", wb_src, 4'b1110);
      check("four_b_rob", wb_rob_idx, {6'd4, 6'd3});
      check("four_b_conflict", arb_conflict, 1'b0);
      tick();
      check("four_idle", wb_valid, 2'b00);

      // ---------------- backpressure on req2 (rr_ptr is 0 here) ----------------
      set_req(0, 6'd20, 6'd1, 32'h20);
      set_req(1, 6'd30, 6'd1, 32'h30);
      set_req(2, 6'd10, 6'd1, 32'h10);
      set_req(3, 6'd40, 6'd1, 32'h40);
      req_valid = 4'b1111;
      tick();                                // P1: all push
      check("bp_p1_valid", wb_valid, 2'b00);
      check("bp_p1_ready", req_ready, 4'hF);
      set_req(0, 6'd21, 6'd1, 32'h21);
      set_req(1, 6'd31, 6'd1, 32'h31);
      set_req(2, 6'd11, 6'd1, 32'h11);
      set_req(3, 6'd41, 6'd1, 32'h41);
      tick();                                // P2
      check("bp_p2_rob", wb_rob_idx, {6'd30, 6'd20});
      check("bp_p2_conflict", arb_conflict, 1'b1);
      check("bp_p2_ready", req_ready, 4'b0011);
      set_req(2, 6'd12, 6'd1, 32'h12);
      req_valid = 4'b0100;                   // third req2 entry waits for ready
      tick();                                // P3: req2 not ready, held
      check("bp_p3_rob", wb_rob_idx, {6'd40, 6'd10});
      check("bp_p3_src", wb_src, 4'b1110);
      check("bp_p3_ready", req_ready, 4'hF);
      tick();                                // P4: third entry accepted
      req_valid = '0;
      check("bp_p4_rob", wb_rob_idx, {6'd31, 6'd21});
      check("bp_p4_ready", req_ready, 4'b1011);
      tick();                                // P5
      check("bp_p5_valid", wb_valid, 2'b11);
      check("bp_p5_rob", wb_rob_idx, {6'd41, 6'd11});
      check("bp_p5_conflict", arb_conflict, 1'b0);
      tick();                                // P6
      check("bp_p6_valid", wb_valid, 2'b01);
      check("bp_p6_rob0", wb_rob_idx[5:0], 6'd12);
      check("bp_p6_src0", wb_src[1:0], 2'd2);
      check("bp_p6_hold1", wb_rob_idx[11:6], 6'd41);
      tick();
      check("bp_idle", wb_valid, 2'b00);

      // ---------------- round-robin fairness ----------------
      flush = 1'b1;
      tick();
      flush = 1'b0;
      set_req(0, 6'd50, 6'd2, 32'h50);
      set_req(2, 6'd52, 6'd2, 32'h52);
      set_req(3, 6'd43, 6'd2, 32'h43);
      req_valid = 4'b0101;
      tick();                                // G1
      check("fair_g1_valid", wb_valid, 2'b00);
      tick();                                // G2
      check("fair_g2_src", wb_src, 4'b1000);
      req_valid = 4'b1101;
      tick();                                // G3: req3 accepted
      req_valid = 4'b0101;
      check("fair_g3_src", wb_src, 4'b1000);
      tick();                                // G4: req3 granted on port 0
      check("fair_g4_valid", wb_valid, 2'b11);
      check("fair_g4_src0", wb_src[1:0], 2'd3);
      check("fair_g4_rob0", wb_rob_idx[5:0], 6'd43);
      check("fair_g4_src1", wb_src[3:2], 2'd0);
      check("fair_g4_conflict", arb_conflict, 1'b1);
      cnt0 = 0;
      cnt2 = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if (wb_valid[k] && wb_src[k*2 +: 2] == 2'd0) cnt0++;
            if (wb_valid[k] && wb_src[k*2 +: 2] == 2'd2) cnt2++;
         end
      end
      check("fair_req0_grants", 64'(cnt0), 64'd20);
      check("fair_req2_grants", 64'(cnt2), 64'd20);
      req_valid = '0;
      tick();
      check("fair_drain", wb_valid, 2'b11);
      tick();
      check("fair_idle", wb_valid, 2'b00);

      // ---------------- flush with four queued entries ----------------
      for (int i = 0; i < 4; i++)
         set_req(i, 6'(60 + i), 6'd3, 32'h60 + 32'(i));
      req_valid = 4'b1111;
      tick();
      req_valid = '0;
      check("fl_ready_before", req_ready, 4'hF);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", wb_valid, 2'b00);
      check("fl_ready", req_ready, 4'hF);
      check("fl_conflict", arb_conflict, 1'b0);
      tick();
      check("fl_gone_1", wb_valid, 2'b00);
      tick();
      check("fl_gone_2", wb_valid, 2'b00);

      // ---------------- async reset mid-drain ----------------
      for (int i = 0; i < 4; i++)
         set_req(i, 6'(70 + i), 6'd4, 32'h70 + 32'(i));
      req_valid = 4'b1111;
      tick();
      req_valid = '0;
      tick();
      check("ar_pre_valid", wb_valid, 2'b11);
      check("ar_pre_src", wb_src, 4'b0100);
      #3 reset = 1'b1;
      #1;
      check("ar_valid", wb_valid, 2'b00);
      check("ar_rob", wb_rob_idx, 12'h0);
      check("ar_src", wb_src, 4'h0);
      check("ar_conflict", arb_conflict, 1'b0);
      check("ar_ready", req_ready, 4'h0);
      tick();
      reset = 1'b0;
      #1;
      check("ar_rel_ready", req_ready, 4'hF);
      set_req(3, 6'd33, 6'd34, 32'h0BADF00D);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      check("ar_lost", wb_valid, 2'b00);
      tick();
      check("ar_new_valid", wb_valid, 2'b01);
      check("ar_new_src", wb_src[1:0], 2'd3);
      check("ar_new_rob", wb_rob_idx[5:0], 6'd33);
      check("ar_new_val", wb_value[31:0], 32'h0BADF00D);
      tick();
      check("ar_idle", wb_valid, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
